snake_collision: RTL and testbench

- Upstream neighbour of the score/seven-segment display stage.
- On each snake move step, checks the new head position against three things: grid bounds, the apple, and every body segment.
- Body segments are fetched serially from the body position memory.
- Emits one-cycle good_coll / bad_coll pulses. These feed the display stage's goodCollButton / badCollButton inputs.

---
 rtl/snake_pkg.sv | 34 +++
 rtl/snake_collision_if.sv | 35 +++
 rtl/snake_collision_point_eq.sv | 13 +
 rtl/snake_collision.sv | 128 ++++++++++++
 tb/tb_snake_collision.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// snake_collision shared types: coordinates, points, grid constants, FSM states.
// Also a helper that clamps a raw snake length into 1..MAX_LEN.
package snake_pkg;

    localparam int COORD_W = 4;
    localparam int GRID_W  = 12;
    localparam int GRID_H  = 8;
    localparam int MAX_LEN = 50;
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [LEN_W-1:0]   len_t;

    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        SCAN,
        REPORT
    } coll_state_t;

    function automatic len_t clamp_len(input len_t len);
        if (len == '0)
            return len_t'(1);
        if (len > len_t'(MAX_LEN))
            return len_t'(MAX_LEN);
        return len;
    endfunction

endpackage

// File: rtl/snake_collision_if.sv
// snake_collision bus: step/head/apple/length in, body memory read port,
// collision pulses and busy out. slave = collision unit, master = its environment.
interface snake_collision_if;
    import snake_pkg::*;

    logic   step;
    coord_t head_x;
    coord_t head_y;
    coord_t apple_x;
    coord_t apple_y;
    len_t   snake_len;
    len_t   body_rd_addr;
    coord_t body_rd_x;
    coord_t body_rd_y;
    logic   good_coll;
    logic   bad_coll;
    logic   busy;

    modport slave (
        input  step, head_x, head_y,
        input  apple_x, apple_y, snake_len,
        input  body_rd_x, body_rd_y,
        output body_rd_addr,
        output good_coll, bad_coll, busy
    );

    modport master (
        output step, head_x, head_y,
        output apple_x, apple_y, snake_len,
        output body_rd_x, body_rd_y,
        input  body_rd_addr,
        input  good_coll, bad_coll, busy
    );

endinterface

// File: rtl/snake_collision_point_eq.sv
// point_eq: combinational equality of two grid points.
// Ports: a, b (point_t) in; eq out, high when both coordinates match.
module point_eq
    import snake_pkg::*;
(
    input  point_t a,
    input  point_t b,
    output logic   eq
);

    assign eq = (a.x == b.x) && (a.y == b.y);

endmodule

// File: rtl/snake_collision.sv
// snake_collision: per-step head check against walls, apple and body segments.
// Ports: clk, rst (async high), bus (snake_collision_if.slave). Macro: SNAKE_WALL_WRAP_EN.
module snake_collision
    import snake_pkg::*;
(
    input  logic clk,
    input  logic rst,
    snake_collision_if.slave bus
);

    localparam coord_t X_LIM = coord_t'(GRID_W);
    localparam coord_t Y_LIM = coord_t'(GRID_H);

    coll_state_t state;
    point_t      head;
    point_t      apple;
    point_t      seg;
    len_t        leff;
    len_t        last_idx;
    len_t        cmp_idx;
    len_t        addr_q;
    logic        apple_hit;
    logic        good_q;
    logic        bad_q;
    logic        busy_q;
    logic        apple_eq;
    logic        seg_eq;
    logic        oob;
    logic        scan_go;

    assign seg = point_t'({bus.body_rd_x, bus.body_rd_y});

    point_eq u_apple_eq (
        .a  (head),
        .b  (apple),
        .eq (apple_eq)
    );

    point_eq u_seg_eq (
        .a  (head),
        .b  (seg),
        .eq (seg_eq)
    );

`ifdef SNAKE_WALL_WRAP_EN
    assign oob = 1'b0;
`else
    assign oob = (head.x >= X_LIM) || (head.y >= Y_LIM);
`endif

    assign last_idx = leff - len_t'(1);
    assign scan_go  = (state == CHECK) && !oob
                    && (leff != len_t'(1));

    // Address 1 goes out during CHECK so its data is
    // ready for the first SCAN compare.
    assign bus.body_rd_addr = scan_go ? len_t'(1) : addr_q;
    assign bus.good_coll    = good_q;
    assign bus.bad_coll     = bad_q;
    assign bus.busy         = busy_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            apple     <= '0;
            leff      <= '0;
            cmp_idx   <= '0;
            addr_q    <= '0;
            apple_hit <= 1'b0;
            good_q    <= 1'b0;
            bad_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.step) begin
                        head.x    <= bus.head_x;
                        head.y    <= bus.head_y;
                        apple.x   <= bus.apple_x;
                        apple.y   <= bus.apple_y;
                        leff      <= clamp_len(bus.snake_len);
                        apple_hit <= 1'b0;
                        busy_q    <= 1'b1;
                        state     <= CHECK;
                    end
                end
                CHECK: begin
                    apple_hit <= apple_eq;
                    if (scan_go) begin
                        addr_q  <= (leff > len_t'(2)) ? len_t'(2)
                                                      : len_t'(1);
                        cmp_idx <= len_t'(1);
                        state   <= SCAN;
                    end else begin
                        bad_q  <= oob;
                        good_q <= apple_eq & ~oob;
                        busy_q <= 1'b0;
                        state  <= REPORT;
                    end
                end
                SCAN: begin
                    if (seg_eq) begin
                        // Self-hit wins over an apple under the body.
                        bad_q  <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= REPORT;
                    end else if (cmp_idx == last_idx) begin
                        good_q <= apple_hit;
                        busy_q <= 1'b0;
                        state  <= REPORT;
                    end else begin
                        cmp_idx <= cmp_idx + len_t'(1);
                        if (addr_q < last_idx)
                            addr_q <= addr_q + len_t'(1);
                    end
                end
                REPORT: begin
                    good_q <= 1'b0;
                    bad_q  <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snake_collision.sv
// Self-checking bench for snake_collision with a serial body memory model.
// Random and directed steps checked against a rule-level outcome model.
module tb_snake_collision;
    import snake_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snake_collision_if bus();

    snake_collision dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [3:0] bx [64];
    logic [3:0] by [64];

    always @(posedge clk) begin
        bus.body_rd_x <= bx[bus.body_rd_addr];
        bus.body_rd_y <= by[bus.body_rd_addr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    int gcyc, gcnt, bcyc, bcnt, both, amax;
    logic [63:0] busy_v;
    bit aconst, rst_ok;

    // Outcome from the game rules: which pulse, at which cycle after step,
    // whether the body is scanned, and the highest address touched.
    task automatic model(input int hx, hy, ax, ay, len,
                         output int eg, eb, ecyc, escan, emax);
        int leff, k;
        bit oob;
        leff = (len < 1) ? 1 : ((len > MAX_LEN) ? MAX_LEN : len);
`ifdef SNAKE_WALL_WRAP_EN
        oob = 1'b0;
`else
        oob = (hx >= GRID_W) || (hy >= GRID_H);
`endif
        eg = 0; eb = 0; escan = 0; emax = 0;
        if (oob) begin
            eb = 1; ecyc = 2;
        end else if (leff == 1) begin
            eg = (hx == ax && hy == ay) ? 1 : 0;
            ecyc = 2;
        end else begin
            escan = 1;
            k = 0;
            for (int i = 1; i < leff; i++)
                if (k == 0 && int'(bx[i]) == hx && int'(by[i]) == hy)
                    k = i;
            if (k != 0) begin
                eb = 1;
                ecyc = k + 2;
                emax = (k + 1 < leff - 1) ? k + 1 : leff - 1;
            end else begin
                eg = (hx == ax && hy == ay) ? 1 : 0;
                ecyc = leff + 1;
                emax = leff - 1;
            end
        end
    endtask

    task automatic run_eval(input int hx, hy, ax, ay, len,
                            input int step2_at, rst_at);
        int a0;
        gcyc = -1; bcyc = -1; gcnt = 0; bcnt = 0; both = 0;
        busy_v = '0; amax = 0; aconst = 1; rst_ok = 1;
        @(negedge clk);
        a0 = int'(bus.body_rd_addr);
        bus.head_x    = hx[3:0];
        bus.head_y    = hy[3:0];
        bus.apple_x   = ax[3:0];
        bus.apple_y   = ay[3:0];
        bus.snake_len = len[5:0];
        bus.step      = 1'b1;
        @(negedge clk);
        bus.step      = 1'b0;
        bus.head_x    = 4'($urandom);
        bus.head_y    = 4'($urandom);
        bus.apple_x   = 4'($urandom);
        bus.apple_y   = 4'($urandom);
        bus.snake_len = 6'($urandom);
        for (int c = 1; c < 61; c++) begin
            if (bus.good_coll) begin
                gcnt++;
                if (gcyc < 0) gcyc = c;
            end
            if (bus.bad_coll) begin
                bcnt++;
                if (bcyc < 0) bcyc = c;
            end
            if (bus.good_coll && bus.bad_coll) both++;
            busy_v[c] = bus.busy;
            if (int'(bus.body_rd_addr) > amax)
                amax = int'(bus.body_rd_addr);
            if (int'(bus.body_rd_addr) != a0) aconst = 0;
            if (c == step2_at) bus.step = 1'b1;
            if (c == rst_at) begin
                rst = 1'b1;
                #1;
                rst_ok = !bus.good_coll && !bus.bad_coll
                      && !bus.busy && bus.body_rd_addr == '0;
            end
            @(negedge clk);
            bus.step = 1'b0;
            rst = 1'b0;
        end
    endtask

    function automatic logic [63:0] busy_mask(input int ecyc);
        logic [63:0] m;
        m = '0;
        for (int c = 1; c < 61; c++) m[c] = (c < ecyc);
        return m;
    endfunction

    task automatic fill_plain();
        for (int i = 0; i < 64; i++) begin
            bx[i] = 4'(i % 11);
            by[i] = 4'((i / 11) % 7);
        end
    endtask

    task automatic test_reset();
        bus.step = 1'b0;
        bus.head_x = '0; bus.head_y = '0;
        bus.apple_x = '0; bus.apple_y = '0;
        bus.snake_len = '0;
        fill_plain();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.good_coll !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_good got %b want 0", bus.good_coll);
        end
        n_cmp++;
        if (bus.bad_coll !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_bad got %b want 0", bus.bad_coll);
        end
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy got %b want 0", bus.busy);
        end
        n_cmp++;
        if (bus.body_rd_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_addr got %0d want 0", bus.body_rd_addr);
        end
        rst = 1'b0;
    endtask

    task automatic test_apple_hit();
        fill_plain();
        bx[1] = 4; by[1] = 5;
        bx[2] = 3; by[2] = 5;
        run_eval(5, 5, 5, 5, 3, 0, 0);
        n_cmp++;
        if (gcyc !== 4 || gcnt !== 1) begin
            n_fail++;
            $display("FAIL apple_good got cyc %0d cnt %0d want 4/1",
                     gcyc, gcnt);
        end
        n_cmp++;
        if (bcnt !== 0) begin
            n_fail++;
            $display("FAIL apple_bad got %0d want 0", bcnt);
        end
        n_cmp++;
        if (busy_v !== 64'he) begin
            n_fail++;
            $display("FAIL apple_busy got %h want e", busy_v);
        end
    endtask

    task automatic test_self_hit();
        fill_plain();
        bx[3] = 2; by[3] = 2;
        run_eval(2, 2, 2, 2, 10, 0, 0);
        n_cmp++;
        if (bcyc !== 5 || bcnt !== 1 || gcnt !== 0) begin
            n_fail++;
            $display("FAIL self_hit got b %0d/%0d g %0d want 5/1/0",
                     bcyc, bcnt, gcnt);
        end
        n_cmp++;
        if (amax !== 4) begin
            n_fail++;
            $display("FAIL self_stop got addr %0d want 4", amax);
        end
    endtask

    task automatic test_wall();
        int eg, eb, ec, es, em;
        fill_plain();
        model(12, 0, 3, 3, 5, eg, eb, ec, es, em);
        run_eval(12, 0, 3, 3, 5, 0, 0);
        n_cmp++;
        if (bcnt !== eb || gcnt !== 0 || (eb == 1 && bcyc !== ec)) begin
            n_fail++;
            $display("FAIL wall5 got b %0d/%0d want %0d/%0d",
                     bcyc, bcnt, ec, eb);
        end
        n_cmp++;
        if (es == 0 && aconst !== 1'b1) begin
            n_fail++;
            $display("FAIL wall_addr got moved want held");
        end
        model(12, 0, 0, 0, 1, eg, eb, ec, es, em);
        run_eval(12, 0, 0, 0, 1, 0, 0);
        n_cmp++;
        if (bcnt !== eb || gcnt !== eg || busy_v !== busy_mask(ec)) begin
            n_fail++;
            $display("FAIL wall1 got b %0d g %0d want %0d/%0d",
                     bcnt, gcnt, eb, eg);
        end
    endtask

    task automatic test_len_bounds();
        fill_plain();
        run_eval(1, 1, 6, 6, 0, 0, 0);
        n_cmp++;
        if (gcnt !== 0 || bcnt !== 0 || busy_v !== 64'h2) begin
            n_fail++;
            $display("FAIL len0 got g %0d b %0d busy %h want 0/0/2",
                     gcnt, bcnt, busy_v);
        end
        run_eval(1, 1, 1, 1, 0, 0, 0);
        n_cmp++;
        if (gcyc !== 2 || gcnt !== 1) begin
            n_fail++;
            $display("FAIL len0_apple got %0d/%0d want 2/1", gcyc, gcnt);
        end
        run_eval(11, 7, 11, 7, 63, 0, 0);
        n_cmp++;
        if (gcyc !== 51 || gcnt !== 1 || bcnt !== 0) begin
            n_fail++;
            $display("FAIL len63 got %0d/%0d want 51/1", gcyc, gcnt);
        end
        n_cmp++;
        if (amax !== 49) begin
            n_fail++;
            $display("FAIL len63_addr got %0d want 49", amax);
        end
    endtask

    task automatic test_step_busy();
        fill_plain();
        run_eval(11, 7, 11, 7, 5, 2, 0);
        n_cmp++;
        if (gcyc !== 6 || gcnt !== 1 || bcnt !== 0) begin
            n_fail++;
            $display("FAIL step_busy got %0d/%0d want 6/1", gcyc, gcnt);
        end
    endtask

    task automatic test_reset_mid();
        fill_plain();
        run_eval(11, 7, 11, 7, 8, 0, 3);
        n_cmp++;
        if (gcnt !== 0 || bcnt !== 0) begin
            n_fail++;
            $display("FAIL rst_mid got g %0d b %0d want 0/0", gcnt, bcnt);
        end
        n_cmp++;
        if (rst_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_mid_out got nonzero want zero");
        end
        run_eval(11, 7, 11, 7, 8, 0, 0);
        n_cmp++;
        if (gcyc !== 9 || gcnt !== 1) begin
            n_fail++;
            $display("FAIL rst_after got %0d/%0d want 9/1", gcyc, gcnt);
        end
    endtask

    task automatic test_random();
        int hx, hy, ax, ay, len, k;
        int eg, eb, ec, es, em;
        for (int n = 0; n < 40; n++) begin
            hx = $urandom_range(0, 13);
            hy = $urandom_range(0, 8);
            for (int i = 0; i < 64; i++) begin
                bx[i] = 4'($urandom_range(0, 5));
                by[i] = 4'($urandom_range(0, 5));
            end
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(1, 49);
                bx[k] = hx[3:0];
                by[k] = hy[3:0];
            end
            if ($urandom_range(0, 1) == 0) begin
                ax = hx; ay = hy;
            end else begin
                ax = $urandom_range(0, 11);
                ay = $urandom_range(0, 7);
            end
            len = $urandom_range(0, 63);
            model(hx, hy, ax, ay, len, eg, eb, ec, es, em);
            run_eval(hx, hy, ax, ay, len, 0, 0);
            n_cmp++;
            if (gcnt !== eg || (eg == 1 && gcyc !== ec)) begin
                n_fail++;
                $display("FAIL rnd%0d_good got %0d@%0d want %0d@%0d",
                         n, gcnt, gcyc, eg, ec);
            end
            n_cmp++;
            if (bcnt !== eb || (eb == 1 && bcyc !== ec)) begin
                n_fail++;
                $display("FAIL rnd%0d_bad got %0d@%0d want %0d@%0d",
                         n, bcnt, bcyc, eb, ec);
            end
            n_cmp++;
            if (both !== 0) begin
                n_fail++;
                $display("FAIL rnd%0d_both got %0d want 0", n, both);
            end
            n_cmp++;
            if (busy_v !== busy_mask(ec)) begin
                n_fail++;
                $display("FAIL rnd%0d_busy got %h want %h",
                         n, busy_v, busy_mask(ec));
            end
            n_cmp++;
            if (es == 1 ? (amax !== em) : (aconst !== 1'b1)) begin
                n_fail++;
                $display("FAIL rnd%0d_addr got %0d want %0d scan %0d",
                         n, amax, em, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_apple_hit();
        test_self_hit();
        test_wall();
        test_len_bounds();
        test_step_busy();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
